rotor_flux_scheduler: RTL and testbench

ROTOR_FLUX_SCHEDULER -- requirements
Module: rotor_flux_scheduler

---
 rtl/rotor_flux_scheduler.sv | 145 ++++++++++++++
 tb/tb_rotor_flux_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotor_flux_scheduler.sv
// rotor_flux_scheduler: time-multiplexed rotor flux update F += Id*K_ID + F*K_FB (sign-magnitude Q12.12).
// Optional macro ROTOR_FLUX_SAT_EN selects saturating multiply/add instead of modulo wrap.  Rev 1.0
`default_nettype none

module rotor_flux_scheduler #(
  parameter logic [23:0] K_ID = 24'h000241,
  parameter logic [23:0] K_FB = 24'h801A36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clr,
  input  logic [23:0] id_in,
  output logic        busy,
  output logic        done,
  output logic [23:0] flux_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_A = 3'd1,
    MUL_B = 3'd2,
    ADD_A = 3'd3,
    ADD_B = 3'd4
  } state_t;

  state_t      state;
  logic [23:0] id_reg;
  logic [23:0] p1;
  logic [23:0] p2;
  logic [23:0] s;
  logic [23:0] flux;

  logic [23:0] mul_a;
  logic [23:0] mul_b;
  logic [45:0] prod_full;
  logic [22:0] mul_mag;
  logic [23:0] mul_res;

  logic [23:0] add_a;
  logic [23:0] add_b;
  logic        a_ge;
  logic        same_sgn;
  logic [22:0] diff_mag;
  logic [22:0] sum_mag;
  logic [22:0] add_mag;
  logic        add_sgn;
  logic [23:0] add_res;

  always_comb begin
    mul_a = id_reg;
    mul_b = K_ID;
    if (state == MUL_B) begin
      mul_a = flux;
      mul_b = K_FB;
    end
  end

  assign prod_full = {23'd0, mul_a[22:0]} * {23'd0, mul_b[22:0]};

  assign add_a = (state == ADD_B) ? flux : p1;
  assign add_b = (state == ADD_B) ? s    : p2;

`ifdef ROTOR_FLUX_SAT_EN
  logic [33:0] prod_sh;
  logic [23:0] sum_full;
  assign prod_sh  = 34'(prod_full >> 12);
  assign mul_mag  = (|prod_sh[33:23]) ? 23'h7FFFFF : prod_sh[22:0];
  assign sum_full = {1'b0, add_a[22:0]} + {1'b0, add_b[22:0]};
  assign sum_mag  = sum_full[23] ? 23'h7FFFFF : sum_full[22:0];
`else
  assign mul_mag  = 23'(prod_full >> 12);
  assign sum_mag  = add_a[22:0] + add_b[22:0];
`endif

  // Zero magnitude always forces a positive sign so -0 never reaches a register.
  assign mul_res  = {(mul_a[23] ^ mul_b[23]) & (|mul_mag), mul_mag};

  assign a_ge     = (add_a[22:0] >= add_b[22:0]);
  assign same_sgn = (add_a[23] == add_b[23]);
  assign diff_mag = a_ge ? (add_a[22:0] - add_b[22:0]) : (add_b[22:0] - add_a[22:0]);
  assign add_mag  = same_sgn ? sum_mag : diff_mag;
  assign add_sgn  = (same_sgn || a_ge) ? add_a[23] : add_b[23];
  assign add_res  = {add_sgn & (|add_mag), add_mag};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      id_reg <= 24'd0;
      p1     <= 24'd0;
      p2     <= 24'd0;
      s      <= 24'd0;
      flux   <= 24'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (clr) begin
      state  <= IDLE;
      id_reg <= 24'd0;
      p1     <= 24'd0;
      p2     <= 24'd0;
      s      <= 24'd0;
      flux   <= 24'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            id_reg <= {id_in[23] & (|id_in[22:0]), id_in[22:0]};
            busy   <= 1'b1;
            state  <= MUL_A;
          end
        end
        MUL_A: begin
          p1    <= mul_res;
          state <= MUL_B;
        end
        MUL_B: begin
          p2    <= mul_res;
          state <= ADD_A;
        end
        ADD_A: begin
          s     <= add_res;
          state <= ADD_B;
        end
        ADD_B: begin
          flux  <= add_res;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign flux_out = flux;

endmodule

`default_nettype wire

// File: tb/tb_rotor_flux_scheduler.sv
// Self-checking bench for rotor_flux_scheduler: arithmetic reference model plus directed and random stimulus.
`default_nettype none

module tb_rotor_flux_scheduler;

`ifdef ROTOR_FLUX_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [23:0] KID = 24'h000241;
  localparam logic [23:0] KFB = 24'h801A36;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic [23:0] id_in = 24'd0;
  logic        busy, done;
  logic [23:0] flux_out;

  logic        start2 = 1'b0;
  logic        clr2 = 1'b0;
  logic [23:0] id2 = 24'd0;
  logic        busy2, done2;
  logic [23:0] flux2;

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  rotor_flux_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .clr(clr), .id_in(id_in),
    .busy(busy), .done(done), .flux_out(flux_out)
  );

  rotor_flux_scheduler #(.K_ID(24'h001000), .K_FB(24'h000000)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .clr(clr2), .id_in(id2),
    .busy(busy2), .done(done2), .flux_out(flux2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on real signed integers.
  function automatic logic [23:0] m_mul(input logic [23:0] a, input logic [23:0] b);
    longint q;
    logic [22:0] mag;
    q = (longint'(a[22:0]) * longint'(b[22:0])) / 4096;
    if (q >= 64'd8388608) mag = SAT ? 23'h7FFFFF : 23'(q % 8388608);
    else mag = 23'(q);
    return {(a[23] ^ b[23]) && (mag != 0), mag};
  endfunction

  function automatic logic [23:0] m_add(input logic [23:0] a, input logic [23:0] b);
    longint va, vb, sum, am;
    logic [22:0] mag;
    va = a[23] ? -longint'(a[22:0]) : longint'(a[22:0]);
    vb = b[23] ? -longint'(b[22:0]) : longint'(b[22:0]);
    sum = va + vb;
    am = (sum < 0) ? -sum : sum;
    if (am >= 64'd8388608) mag = SAT ? 23'h7FFFFF : 23'(am % 8388608);
    else mag = 23'(am);
    return {(sum < 0) && (mag != 0), mag};
  endfunction

  function automatic logic [23:0] m_step(input logic [23:0] f, input logic [23:0] id);
    return m_add(f, m_add(m_mul(id, KID), m_mul(f, KFB)));
  endfunction

  logic [23:0] m_f = 24'd0;
  logic [23:0] m_id = 24'd0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;

  // Cycle-level behaviour: 0 = idle, 1..4 = cycles since accept; result lands on the 4th edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_f <= 24'd0; m_id <= 24'd0; m_cnt <= 0; m_done <= 1'b0;
    end else if (clr) begin
      m_f <= 24'd0; m_cnt <= 0; m_done <= 1'b0;
    end else if (m_cnt == 0) begin
      m_done <= 1'b0;
      if (start) begin
        m_id <= id_in;
        m_cnt <= 1;
      end
    end else if (m_cnt < 4) begin
      m_cnt <= m_cnt + 1;
    end else begin
      m_f <= m_step(m_f, m_id);
      m_done <= 1'b1;
      m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("busy", {23'd0, busy}, {23'd0, (m_cnt != 0)});
      chk("done", {23'd0, done}, {23'd0, m_done});
      chk("flux_out", flux_out, m_f);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!done && n < 20);
  endtask

  int n, dcount, first_d, second_d;

  initial begin
    cyc(2);
    chk("reset_flux", flux_out, 24'h000000);
    chk("reset_busy", {23'd0, busy}, 24'd0);
    chk("reset_done", {23'd0, done}, 24'd0);
    chk("model_p2", m_mul(24'h000241, 24'h801A36), 24'h8003B1);
    chk("model_s", m_add(24'h000241, 24'h8003B1), 24'h800170);
    chk("model_negzero", m_add(24'h800005, 24'h000005), 24'h000000);
    #2 reset = 1'b1;
    run = 1'b1;

    // Two chained steps with saturating vs wrapping second add.
    id2 = 24'h7FFFFF;
    start2 = 1'b1; cyc(1); start2 = 1'b0;
    cyc(5);
    chk("sat_step1", flux2, 24'h7FFFFF);
    start2 = 1'b1; cyc(1); start2 = 1'b0;
    cyc(5);
    chk("sat_step2", flux2, SAT ? 24'h7FFFFF : 24'h7FFFFE);

    // First step from zero flux.
    id_in = 24'h001000; start = 1'b1; cyc(1); start = 1'b0;
    wait_done(n);
    chk("latency1", n, 4);
    chk("step1_flux", flux_out, 24'h000241);
    cyc(1);
    start = 1'b1; cyc(1); start = 1'b0;
    wait_done(n);
    chk("latency2", n, 4);
    chk("step2_flux", flux_out, 24'h0000D1);
    cyc(1);

    // Start held high: only accepts from IDLE, no queuing.
    dcount = 0; first_d = 0; second_d = 0;
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      if (done) begin
        dcount++;
        if (dcount == 1) first_d = k;
        else second_d = k;
      end
    end
    start = 1'b0;
    chk("hold_done_count", dcount, 2);
    chk("hold_done_gap", second_d - first_d, 5);
    cyc(2);

    // clr in MUL_B together with start.
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    clr = 1'b1; start = 1'b1; cyc(1); clr = 1'b0; start = 1'b0;
    chk("clr_flux", flux_out, 24'h000000);
    chk("clr_busy", {23'd0, busy}, 24'd0);
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      if (done) dcount++;
    end
    chk("clr_no_done", dcount, 0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      start = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 4))
        0: id_in = 24'h800000;
        1: id_in = {$urandom_range(0, 1) == 1, 23'h7FFFFF};
        default: id_in = 24'($urandom);
      endcase
      cyc(1);
    end
    start = 1'b0; clr = 1'b0;
    cyc(6);

    // Reset in ADD_A aborts the step, then a fresh step from zero.
    id_in = 24'h001000; start = 1'b1; cyc(1); start = 1'b0;
    cyc(2);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_flux", flux_out, 24'h000000);
    chk("rst_mid_busy", {23'd0, busy}, 24'd0);
    chk("rst_mid_done", {23'd0, done}, 24'd0);
    cyc(2);
    #2 reset = 1'b1; start = 1'b1;
    cyc(1); start = 1'b0;
    wait_done(n);
    chk("post_rst_latency", n, 4);
    chk("post_rst_flux", flux_out, 24'h000241);
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
